// File: rtl/spi_pkg.sv
// Shared constants and FSM state encoding for the 64-bit SPI initiator.
package spi_pkg;
    localparam int FRAME_BITS = 64;
    localparam int OPERAND_W  = 32;
    localparam int HALVES_W   = 8;

    typedef enum logic [2:0] {IDLE, LOW, HIGH, TAIL, GAP} spi_state_e;
endpackage

// File: rtl/spi_half_period_timer.sv
// Loadable down-counter: expire is high in the last cycle of an interval of
// halves*HALF_PERIOD_CYCLES cycles that starts the cycle after load.
module spi_half_period_timer
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD_CYCLES = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [HALVES_W-1:0] halves,
    output logic                expire
);
    localparam int CW = $clog2(HALF_PERIOD_CYCLES + 1);
    localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD_CYCLES - 1);

    logic [CW-1:0]       cyc_cnt;
    logic [HALVES_W-1:0] half_cnt;

    assign expire = (cyc_cnt == '0) && (half_cnt == '0);

    // Holds at zero once expired until the FSM reloads it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt  <= '0;
            half_cnt <= '0;
        end else if (load) begin
            cyc_cnt  <= HP_LAST;
            half_cnt <= halves - HALVES_W'(1);
        end else if (!expire) begin
            if (cyc_cnt == '0) begin
                cyc_cnt  <= HP_LAST;
                half_cnt <= half_cnt - HALVES_W'(1);
            end else begin
                cyc_cnt <= cyc_cnt - CW'(1);
            end
        end
    end
endmodule

// File: rtl/spi_master_64bit.sv
// SPI mode-0 initiator: one 64-bit frame out on PICO, 64-bit result in on POCI.
// Define SPI_MASTER_LOOPBACK_EN to feed the rx path from SPI_PICO instead of SPI_POCI.
module spi_master_64bit
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD_CYCLES = 5,
    parameter int TAIL_HALF_PERIODS  = 2,
    parameter int GAP_HALF_PERIODS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [OPERAND_W-1:0]  operand1,
    input  logic [OPERAND_W-1:0]  operand2,
    output logic                  busy,
    output logic                  done,
    output logic [FRAME_BITS-1:0] result,
    output logic                  SPI_CLK,
    output logic                  SPI_PICO,
    output logic                  SPI_CS,
    input  logic                  SPI_POCI
);
    spi_state_e state, state_n;

    logic                  tmr_load, expire;
    logic [HALVES_W-1:0]   tmr_halves;
    logic                  accept, rise, sample, shift, finish, gap_end;
    logic [FRAME_BITS-1:0] tx, rx;
    logic [5:0]            bit_cnt;
    logic [1:0]            poci_sync;
    logic                  sample_d;
    logic                  rx_src;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign rx_src = SPI_PICO;
`else
    assign rx_src = SPI_POCI;
`endif

    // PICO is the tx MSB flop itself, so it holds after the last bit and clears on reset.
    assign SPI_PICO = tx[FRAME_BITS-1];

    spi_half_period_timer #(.HALF_PERIOD_CYCLES(HALF_PERIOD_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .halves (tmr_halves),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        tmr_load   = 1'b0;
        tmr_halves = HALVES_W'(1);
        accept     = 1'b0;
        rise       = 1'b0;
        sample     = 1'b0;
        shift      = 1'b0;
        finish     = 1'b0;
        gap_end    = 1'b0;
        unique case (state)
            IDLE: if (start) begin
                state_n  = LOW;
                tmr_load = 1'b1;
                accept   = 1'b1;
            end
            LOW: if (expire) begin
                state_n  = HIGH;
                tmr_load = 1'b1;
                rise     = 1'b1;
            end
            HIGH: if (expire) begin
                sample   = 1'b1;
                tmr_load = 1'b1;
                if (bit_cnt == 6'd63) begin
                    state_n    = TAIL;
                    tmr_halves = HALVES_W'(TAIL_HALF_PERIODS);
                end else begin
                    state_n = LOW;
                    shift   = 1'b1;
                end
            end
            TAIL: if (expire) begin
                state_n    = GAP;
                tmr_load   = 1'b1;
                tmr_halves = HALVES_W'(GAP_HALF_PERIODS);
                finish     = 1'b1;
            end
            GAP: if (expire) begin
                state_n = IDLE;
                gap_end = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // The rx shift lands one cycle after the SCLK fall so that the second sync
    // stage reflects the pin as it was during the high phase, even with H=1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poci_sync <= '0;
            sample_d  <= 1'b0;
            tx        <= '0;
            rx        <= '0;
            bit_cnt   <= '0;
            SPI_CS    <= 1'b1;
            SPI_CLK   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            poci_sync <= {poci_sync[0], rx_src};
            sample_d  <= sample;
            done      <= 1'b0;
            if (sample_d) rx <= {rx[FRAME_BITS-2:0], poci_sync[1]};
            if (accept) begin
                tx      <= {operand1, operand2};
                rx      <= '0;
                bit_cnt <= '0;
                SPI_CS  <= 1'b0;
                SPI_CLK <= 1'b0;
                busy    <= 1'b1;
            end
            if (rise) SPI_CLK <= 1'b1;
            if (sample) begin
                SPI_CLK <= 1'b0;
                if (shift) begin
                    bit_cnt <= bit_cnt + 6'd1;
                    tx      <= {tx[FRAME_BITS-2:0], 1'b0};
                end
            end
            if (finish) begin
                SPI_CS <= 1'b1;
                result <= rx;
                done   <= 1'b1;
            end
            if (gap_end) busy <= 1'b0;
        end
    end
endmodule
